brick_hit_resolver: RTL and testbench

Sits directly upstream of the brick matrix. Watches the pixel stream for the first pixel per frame where the bullet and a brick are both drawn, and converts that pixel into brick grid coordinates. At the next start of frame it issues one clean collision handshake (high for a fixed hold, then low) on `collision`, `brickCollision1X` and `brickCollision1Y`. The brick matrix uses that handshake to degrade or remove exactly one brick per hit. It also pulses `bulletHit` so the bullet controller can retire the bullet.

---
 rtl/brick_hit_resolver.sv | 121 ++++++++++++
 tb/tb_brick_hit_resolver.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/brick_hit_resolver.sv
// Finds the first bullet/brick overlap pixel of a frame and converts it to grid coordinates.
// At the next start of frame it issues one registered collision handshake to the brick matrix.
module brick_hit_resolver #(
  parameter int BLOCK_SIZE_LOG2   = 5,
  parameter int BLOCKS_PER_ROW    = 17,
  parameter int BLOCKS_PER_COLUMN = 14,
  parameter int HOLD_CYCLES       = 4
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic [10:0] pixelX,
  input  logic [10:0] pixelY,
  input  logic [10:0] topLeftX,
  input  logic [10:0] topLeftY,
  input  logic        bulletDrawingRequest,
  input  logic        bricksDrawingRequest,
  output logic        collision,
  output logic [4:0]  brickCollision1X,
  output logic [3:0]  brickCollision1Y,
  output logic        bulletHit,
  output logic        busy,
  output logic [7:0]  hitCount
);

  typedef enum logic [1:0] {IDLE, CAPTURED, ISSUE, RELEASE} state_t;

  localparam logic [3:0]  HOLD_LOAD = 4'(HOLD_CYCLES - 1);
  localparam logic [10:0] ROW_LIM   = 11'(BLOCKS_PER_ROW);
  localparam logic [10:0] COL_LIM   = 11'(BLOCKS_PER_COLUMN);

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_t      state, state_nxt;
  logic [3:0]  hold_cnt, hold_cnt_nxt;
  logic [4:0]  x_nxt;
  logic [3:0]  y_nxt;
  logic        hit_nxt;
  logic [7:0]  count_nxt;

  logic [10:0] px_p1, py_p1;
  logic [10:0] rel_x, rel_y, gx, gy;
  logic        in_grid, overlap;

  // stage p1: pixel position aligned with the registered drawing requests
  always_ff @(posedge clk) begin
    px_p1 <= pixelX;
    py_p1 <= pixelY;
  end

  always_comb begin
    rel_x   = px_p1 - topLeftX;
    rel_y   = py_p1 - topLeftY;
    gx      = rel_x >> BLOCK_SIZE_LOG2;
    gy      = rel_y >> BLOCK_SIZE_LOG2;
    // the >= tests reject pixels whose subtraction wrapped to a large value
    in_grid = (px_p1 >= topLeftX) && (py_p1 >= topLeftY) && (gx < ROW_LIM) && (gy < COL_LIM);
    overlap = bulletDrawingRequest && bricksDrawingRequest && in_grid;
  end

  always_comb begin
    state_nxt    = state;
    hold_cnt_nxt = hold_cnt;
    x_nxt        = brickCollision1X;
    y_nxt        = brickCollision1Y;
    hit_nxt      = 1'b0;
    count_nxt    = hitCount;
    case (state)
      IDLE: begin
        if (overlap) begin
          x_nxt     = gx[4:0];
          y_nxt     = gy[3:0];
          hit_nxt   = 1'b1;
          state_nxt = CAPTURED;
        end
      end
      CAPTURED: begin
        if (startOfFrame) begin
          hold_cnt_nxt = HOLD_LOAD;
          state_nxt    = ISSUE;
        end
      end
      ISSUE: begin
        if (hold_cnt == 4'd0) begin
          state_nxt = RELEASE;
          count_nxt = sat_inc(hitCount);
        end else begin
          hold_cnt_nxt = hold_cnt - 4'd1;
        end
      end
      RELEASE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // stage p2: state and every output registered from the next-state decode
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state            <= IDLE;
      hold_cnt         <= 4'd0;
      collision        <= 1'b0;
      brickCollision1X <= 5'd0;
      brickCollision1Y <= 4'd0;
      bulletHit        <= 1'b0;
      busy             <= 1'b0;
      hitCount         <= 8'd0;
    end else begin
      state            <= state_nxt;
      hold_cnt         <= hold_cnt_nxt;
      collision        <= (state_nxt == ISSUE);
      brickCollision1X <= x_nxt;
      brickCollision1Y <= y_nxt;
      bulletHit        <= hit_nxt;
      busy             <= (state_nxt != IDLE);
      hitCount         <= count_nxt;
    end
  end

endmodule

// File: tb/tb_brick_hit_resolver.sv
// Bench for brick_hit_resolver: vector table, directed corner sequences and a
// randomized run checked every cycle against a timeline-based reference model.
module tb_brick_hit_resolver;

  localparam int H = 4;

  logic        clk = 1'b0;
  logic        resetN;
  logic        startOfFrame;
  logic [10:0] pixelX, pixelY, topLeftX, topLeftY;
  logic        bulletDrawingRequest, bricksDrawingRequest;
  logic        collision;
  logic [4:0]  brickCollision1X;
  logic [3:0]  brickCollision1Y;
  logic        bulletHit, busy;
  logic [7:0]  hitCount;

  brick_hit_resolver #(
    .BLOCK_SIZE_LOG2(5), .BLOCKS_PER_ROW(17), .BLOCKS_PER_COLUMN(14), .HOLD_CYCLES(H)
  ) dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
    .pixelX(pixelX), .pixelY(pixelY), .topLeftX(topLeftX), .topLeftY(topLeftY),
    .bulletDrawingRequest(bulletDrawingRequest), .bricksDrawingRequest(bricksDrawingRequest),
    .collision(collision), .brickCollision1X(brickCollision1X), .brickCollision1Y(brickCollision1Y),
    .bulletHit(bulletHit), .busy(busy), .hitCount(hitCount)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 0;
  int tally = 0;
  int last_x = 0, last_y = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  function automatic bit in_grid(input int px, input int py, input int tx, input int ty,
                                 output int gx, output int gy);
    int rx, ry;
    rx = px - tx;
    ry = py - ty;
    gx = 0;
    gy = 0;
    if (rx < 0 || ry < 0) return 0;
    gx = rx / 32;
    gy = ry / 32;
    return (gx < 17) && (gy < 14);
  endfunction

  // Reference model on an absolute edge timeline: m_iss is the edge at which the
  // issuing start of frame was seen; collision spans edges m_iss..m_iss+H-1.
  int m_cyc, m_iss, m_hits, m_x, m_y;
  bit m_capt, m_bullet;
  int prev_px, prev_py;

  always @(posedge clk) begin
    int gx, gy;
    bit ov;
    if (!resetN) begin
      m_cyc = 0; m_iss = -100; m_hits = 0; m_x = 0; m_y = 0; m_capt = 0; m_bullet = 0;
    end else begin
      m_cyc++;
      m_bullet = 0;
      ov = bulletDrawingRequest && bricksDrawingRequest &&
           in_grid(prev_px, prev_py, int'(topLeftX), int'(topLeftY), gx, gy);
      if (m_capt && startOfFrame) begin
        m_iss  = m_cyc;
        m_capt = 0;
      end else if (!m_capt && m_cyc > m_iss + H + 1 && ov) begin
        m_capt = 1; m_x = gx; m_y = gy; m_bullet = 1;
      end
      if (m_cyc == m_iss + H && m_hits < 255) m_hits++;
    end
    prev_px = int'(pixelX);
    prev_py = int'(pixelY);
    #1;
    if (chk_en) begin
      chk("model_collision", int'(collision), int'(m_cyc >= m_iss && m_cyc <= m_iss + H - 1));
      chk("model_busy", int'(busy), int'(m_capt || m_cyc <= m_iss + H));
      chk("model_bullethit", int'(bulletHit), int'(m_bullet));
      chk("model_x", int'(brickCollision1X), m_x);
      chk("model_y", int'(brickCollision1Y), m_y);
      chk("model_hitcount", int'(hitCount), m_hits);
    end
  end

  task automatic do_overlap(input int px, input int py);
    pixelX = 11'(px);
    pixelY = 11'(py);
    tick;
    bulletDrawingRequest = 1'b1;
    bricksDrawingRequest = 1'b1;
    pixelX = 11'd0;
    pixelY = 11'd0;
    tick;
    bulletDrawingRequest = 1'b0;
    bricksDrawingRequest = 1'b0;
  endtask

  task automatic issue_and_check;
    int n;
    startOfFrame = 1'b1;
    tick;
    startOfFrame = 1'b0;
    n = 0;
    while (collision && n < 20) begin
      chk("hs_x", int'(brickCollision1X), last_x);
      chk("hs_y", int'(brickCollision1Y), last_y);
      n++;
      tick;
    end
    chk("hs_high_cycles", n, H);
    chk("hs_release_busy", int'(busy), 1);
    if (tally < 255) tally++;
    chk("hs_hitcount", int'(hitCount), tally);
    tick;
    chk("hs_idle", int'(busy), 0);
    chk("hs_low_after", int'(collision), 0);
  endtask

  typedef struct {
    int tlx, tly, px, py;
    bit hit;
    int ex, ey;
  } vec_t;

  vec_t vecs[10];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hits;
    vecs[0] = '{0,   0,  100, 40,  1, 3,  1};
    vecs[1] = '{64,  32, 10,  10,  0, 0,  0};
    vecs[2] = '{64,  32, 608, 40,  0, 0,  0};
    vecs[3] = '{64,  32, 607, 479, 1, 16, 13};
    vecs[4] = '{0,   0,  0,   0,   1, 0,  0};
    vecs[5] = '{0,   0,  543, 447, 1, 16, 13};
    vecs[6] = '{0,   0,  544, 0,   0, 0,  0};
    vecs[7] = '{0,   0,  0,   448, 0, 0,  0};
    vecs[8] = '{100, 50, 99,  60,  0, 0,  0};
    vecs[9] = '{100, 50, 132, 82,  1, 1,  1};

    resetN = 1'b0;
    startOfFrame = 1'b0;
    pixelX = '0; pixelY = '0; topLeftX = '0; topLeftY = '0;
    bulletDrawingRequest = 1'b0;
    bricksDrawingRequest = 1'b0;
    tick; tick; tick;
    chk("rst_collision", int'(collision), 0);
    chk("rst_x", int'(brickCollision1X), 0);
    chk("rst_y", int'(brickCollision1Y), 0);
    chk("rst_bullethit", int'(bulletHit), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_hitcount", int'(hitCount), 0);
    resetN = 1'b1;
    chk_en = 1;
    tick;

    for (int i = 0; i < 10; i++) begin
      topLeftX = 11'(vecs[i].tlx);
      topLeftY = 11'(vecs[i].tly);
      do_overlap(vecs[i].px, vecs[i].py);
      if (vecs[i].hit) begin
        last_x = vecs[i].ex;
        last_y = vecs[i].ey;
      end
      chk("vec_bullethit", int'(bulletHit), int'(vecs[i].hit));
      chk("vec_busy", int'(busy), int'(vecs[i].hit));
      chk("vec_x", int'(brickCollision1X), last_x);
      chk("vec_y", int'(brickCollision1Y), last_y);
      tick;
      chk("vec_pulse_end", int'(bulletHit), 0);
      if (vecs[i].hit) issue_and_check();
      else chk("vec_no_busy", int'(busy), 0);
    end

    // three overlaps in one frame: only the first is captured
    topLeftX = 11'd0; topLeftY = 11'd0;
    pixelX = 11'd40; pixelY = 11'd40;
    tick;
    bulletDrawingRequest = 1'b1; bricksDrawingRequest = 1'b1;
    pixelX = 11'd200; pixelY = 11'd200;
    hits = 0;
    tick; hits += int'(bulletHit);
    pixelX = 11'd300; pixelY = 11'd10;
    tick; hits += int'(bulletHit);
    tick; hits += int'(bulletHit);
    bulletDrawingRequest = 1'b0; bricksDrawingRequest = 1'b0;
    tick; hits += int'(bulletHit);
    chk("multi_pulses", hits, 1);
    last_x = 1; last_y = 1;
    chk("multi_x", int'(brickCollision1X), 1);
    chk("multi_y", int'(brickCollision1Y), 1);
    issue_and_check();

    // overlap and start of frame in the same cycle
    pixelX = 11'd100; pixelY = 11'd40;
    tick;
    bulletDrawingRequest = 1'b1; bricksDrawingRequest = 1'b1; startOfFrame = 1'b1;
    tick;
    bulletDrawingRequest = 1'b0; bricksDrawingRequest = 1'b0; startOfFrame = 1'b0;
    chk("same_busy", int'(busy), 1);
    chk("same_bullethit", int'(bulletHit), 1);
    for (int i = 0; i < 5; i++) begin
      chk("same_no_collision", int'(collision), 0);
      tick;
    end
    last_x = 3; last_y = 1;
    issue_and_check();

    // reset asserted on the second issue cycle
    do_overlap(100, 40);
    startOfFrame = 1'b1;
    tick;
    startOfFrame = 1'b0;
    chk("rst_mid_issue1", int'(collision), 1);
    tick;
    chk("rst_mid_issue2", int'(collision), 1);
    chk_en = 0;
    resetN = 1'b0;
    #1;
    chk("rst_async_collision", int'(collision), 0);
    chk("rst_async_busy", int'(busy), 0);
    tick; tick;
    resetN = 1'b1;
    tick;
    chk("rst_after_collision", int'(collision), 0);
    chk("rst_after_x", int'(brickCollision1X), 0);
    chk("rst_after_y", int'(brickCollision1Y), 0);
    chk("rst_after_bullethit", int'(bulletHit), 0);
    chk("rst_after_busy", int'(busy), 0);
    chk("rst_after_hitcount", int'(hitCount), 0);
    tally = 0; last_x = 0; last_y = 0;
    chk_en = 1;

    // 260 hits: counter saturates, every handshake keeps its shape
    topLeftX = 11'd0; topLeftY = 11'd0;
    last_x = 1; last_y = 1;
    for (int i = 0; i < 260; i++) begin
      do_overlap(40, 40);
      issue_and_check();
    end
    chk("sat_hitcount", int'(hitCount), 255);

    // randomized frames checked by the reference model
    for (int f = 0; f < 60; f++) begin
      topLeftX = 11'($urandom_range(0, 200));
      topLeftY = 11'($urandom_range(0, 200));
      startOfFrame = 1'b1;
      tick;
      startOfFrame = 1'b0;
      for (int c = 0; c < 39; c++) begin
        pixelX = 11'($urandom_range(0, 900));
        pixelY = 11'($urandom_range(0, 700));
        bulletDrawingRequest = ($urandom_range(0, 3) == 0);
        bricksDrawingRequest = ($urandom_range(0, 1) == 0);
        tick;
      end
    end
    bulletDrawingRequest = 1'b0;
    bricksDrawingRequest = 1'b0;
    tick; tick;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
